vr_onehot_l_ctr_enc: RTL and testbench

//  Receive-side companion to the 3-bit counter/active-low decoder. Samples an
//  N-line active-low one-hot bus S_L, encodes it back to a binary count, and

---
 rtl/vr_onehot_l_ctr_enc_pkg.sv | 13 +
 rtl/vr_onehot_l_enc.sv | 30 +++
 rtl/vr_onehot_l_ctr_enc.sv | 130 +++++++++++++
 tb/tb_vr_onehot_l_ctr_enc.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vr_onehot_l_ctr_enc_pkg.sv
// rtl/vr_onehot_l_ctr_enc_pkg.sv - shared FSM encoding and default sizes for the one-hot receive checker
package vr_onehot_l_ctr_enc_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_W = $clog2(DEF_N);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } vr_state_e;

endpackage

// File: rtl/vr_onehot_l_enc.sv
// rtl/vr_onehot_l_enc.sv - combinational active-low one-hot to {legal, index} encoder
module vr_onehot_l_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [0:N-1] s_l_i,
    output logic         legal_o,
    output logic [W-1:0] idx_o
);

    logic found;
    logic multi;

    // idx_o only carries meaning when exactly one line is low
    always_comb begin
        found = 1'b0;
        multi = 1'b0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (!s_l_i[i]) begin
                if (found) multi = 1'b1;
                found = 1'b1;
                idx_o = W'(i);
            end
        end
    end

    assign legal_o = found & ~multi;

endmodule

// File: rtl/vr_onehot_l_ctr_enc.sv
// rtl/vr_onehot_l_ctr_enc.sv - one-hot select bus encoder with +1 sequence lock checker; VR_ONEHOT_ERRCNT_EN adds an error counter
module vr_onehot_l_ctr_enc
    import vr_onehot_l_ctr_enc_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = $clog2(N),
    parameter int LOCK_CNT = 2
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [0:N-1] s_l_i,
    output logic [W-1:0] q_o,
    output logic         valid_o,
    output logic         locked_o,
    output logic         err_code_o,
`ifdef VR_ONEHOT_ERRCNT_EN
    output logic [7:0]   err_cnt_o,
    output logic         err_seq_o
`else
    output logic         err_seq_o
`endif
);

    vr_state_e      state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic           valid_q, valid_d;
    logic           locked_q, locked_d;
    logic           err_code_q, err_code_d;
    logic           err_seq_q, err_seq_d;
    logic [2:0]     good_q, good_d;
    logic           legal;
    logic [W-1:0]   idx;
    logic [W-1:0]   exp_idx;
    logic [2:0]     good_inc;

    vr_onehot_l_enc #(.N(N), .W(W)) u_enc (
        .s_l_i   (s_l_i),
        .legal_o (legal),
        .idx_o   (idx)
    );

    assign exp_idx  = q_q + W'(1);
    assign good_inc = good_q + 3'd1;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q    <= ST_ACQUIRE;
            q_q        <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_code_q <= 1'b0;
            err_seq_q  <= 1'b0;
            good_q     <= '0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            err_code_q <= err_code_d;
            err_seq_q  <= err_seq_d;
            good_q     <= good_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        valid_d    = valid_q;
        good_d     = good_q;
        err_code_d = 1'b0;
        err_seq_d  = 1'b0;
        if (en_i) begin
            if (!legal) begin
                valid_d    = 1'b0;
                err_code_d = 1'b1;
                good_d     = '0;
                state_d    = (state_q == ST_TRACK) ? ST_FAULT : ST_ACQUIRE;
            end else begin
                q_d     = idx;
                valid_d = 1'b1;
                case (state_q)
                    ST_TRACK: begin
                        if (idx != exp_idx) begin
                            err_seq_d = 1'b1;
                            good_d    = '0;
                            state_d   = ST_FAULT;
                        end
                    end
                    // FAULT re-enters acquisition with good already zeroed
                    default: begin
                        state_d = ST_ACQUIRE;
                        if (valid_q && (idx == exp_idx)) begin
                            if (good_inc == 3'(LOCK_CNT)) begin
                                good_d  = '0;
                                state_d = ST_TRACK;
                            end else begin
                                good_d  = good_inc;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                endcase
            end
        end
        locked_d = (state_d == ST_TRACK);
    end

    assign q_o        = q_q;
    assign valid_o    = valid_q;
    assign locked_o   = locked_q;
    assign err_code_o = err_code_q;
    assign err_seq_o  = err_seq_q;

`ifdef VR_ONEHOT_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            err_cnt_q <= '0;
        end else if ((err_code_d || err_seq_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_vr_onehot_l_ctr_enc.sv
// tb/tb_vr_onehot_l_ctr_enc.sv - directed self-checking bench for vr_onehot_l_ctr_enc
module tb_vr_onehot_l_ctr_enc;

    logic       clk;
    logic       clr;
    logic       en;
    logic [0:7] s_l;
    logic [2:0] q;
    logic       valid;
    logic       locked;
    logic       err_code;
    logic       err_seq;
`ifdef VR_ONEHOT_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vr_onehot_l_ctr_enc dut (
        .clk_i      (clk),
        .clr_i      (clr),
        .en_i       (en),
        .s_l_i      (s_l),
        .q_o        (q),
        .valid_o    (valid),
        .locked_o   (locked),
        .err_code_o (err_code),
`ifdef VR_ONEHOT_ERRCNT_EN
        .err_cnt_o  (err_cnt),
`endif
        .err_seq_o  (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:7] oh(input int idx);
        logic [0:7] v;
        v = 8'hFF;
        v[idx] = 1'b0;
        return v;
    endfunction

    task automatic cyc(input logic [0:7] s, input logic e);
        s_l = s;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int eq, input int ev, input int el,
                           input int ec, input int es);
        chk({tag, ".q"},        32'(q),        32'(eq));
        chk({tag, ".valid"},    32'(valid),    32'(ev));
        chk({tag, ".locked"},   32'(locked),   32'(el));
        chk({tag, ".err_code"}, 32'(err_code), 32'(ec));
        chk({tag, ".err_seq"},  32'(err_seq),  32'(es));
    endtask

    initial begin
        clr = 1'b1;
        en  = 1'b0;
        s_l = 8'hFF;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        #1;
        clr = 1'b0;

        // count 0..7 then wrap to 0; lock on the third legal sample
        for (int i = 0; i < 8; i++) begin
            cyc(oh(i), 1'b1);
            chk_all($sformatf("count%0d", i), i, 1, (i >= 2) ? 1 : 0, 0, 0);
        end
        cyc(oh(0), 1'b1);
        chk_all("wrap", 0, 1, 1, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(oh(i), 1'b1);
        chk_all("track5", 5, 1, 1, 0, 0);

        // sequence break: idx 2 after 5
        cyc(8'b11011111, 1'b1);
        chk_all("seqbrk", 2, 1, 0, 0, 1);
        cyc(oh(3), 1'b1);
        chk_all("relock1", 3, 1, 0, 0, 0);
        cyc(oh(4), 1'b1);
        chk_all("relock2", 4, 1, 1, 0, 0);

        // enable low: everything holds while the bus wanders
        cyc(oh(7), 1'b0);
        chk_all("hold0", 4, 1, 1, 0, 0);
        cyc(8'hFF, 1'b0);
        chk_all("hold1", 4, 1, 1, 0, 0);
        cyc(oh(1), 1'b0);
        chk_all("hold2", 4, 1, 1, 0, 0);
        cyc(8'b00111111, 1'b0);
        chk_all("hold3", 4, 1, 1, 0, 0);
        cyc(oh(5), 1'b1);
        chk_all("resume", 5, 1, 1, 0, 0);

        // illegal codes in TRACK
        cyc(8'hFF, 1'b1);
        chk_all("allhigh", 5, 0, 0, 1, 0);
        cyc(8'b00111111, 1'b1);
        chk_all("twolow", 5, 0, 0, 1, 0);
        cyc(oh(6), 1'b1);
        chk_all("base6", 6, 1, 0, 0, 0);
        cyc(oh(7), 1'b1);
        chk_all("acq7", 7, 1, 0, 0, 0);
        cyc(oh(0), 1'b1);
        chk_all("acq0", 0, 1, 1, 0, 0);

        // async clear with an error pulse live
        cyc(oh(3), 1'b1);
        chk_all("preclr", 3, 1, 0, 0, 1);
        clr = 1'b1;
        #1;
        chk_all("asyncclr", 0, 0, 0, 0, 0);
        #1;
        clr = 1'b0;
        cyc(oh(1), 1'b1);
        chk_all("postclr1", 1, 1, 0, 0, 0);
        cyc(oh(2), 1'b1);
        chk_all("postclr2", 2, 1, 0, 0, 0);
        cyc(oh(3), 1'b1);
        chk_all("postclr3", 3, 1, 1, 0, 0);

`ifdef VR_ONEHOT_ERRCNT_EN
        clr = 1'b1;
        #1;
        clr = 1'b0;
        chk("errcnt.clr", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 10; i++) cyc(8'hFF, 1'b1);
        chk("errcnt.10", 32'(err_cnt), 32'd10);
        for (int i = 10; i < 300; i++) cyc(8'hFF, 1'b1);
        chk("errcnt.sat", 32'(err_cnt), 32'hFF);
        cyc(8'b00111111, 1'b1);
        cyc(oh(2), 1'b0);
        chk("errcnt.hold", 32'(err_cnt), 32'hFF);
        clr = 1'b1;
        #1;
        chk("errcnt.rst", 32'(err_cnt), 32'h0);
        #1;
        clr = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
